// File: rtl/ysyx_23060240_sram_resp_pkg.sv
// Shared definitions for the SRAM responder: response codes, FSM state
// encodings and the LFSR reset seed.
package ysyx_23060240_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [7:0] LFSR_SEED = 8'hA5;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_RESP = 2'd2
   } r_state_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_WAIT = 2'd1,
      W_RESP = 2'd2
   } w_state_t;

endpackage

// File: rtl/ysyx_23060240_sram_resp_if.sv
// Valid/ready bus between the load/store initiator (master) and the
// SRAM responder (slave): independent read (AR/R) and write (AW/W/B) channels.
interface ysyx_23060240_sram_resp_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output araddr, arvalid, rready,
      output awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready,
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid,
      output awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/ysyx_23060240_sram_resp_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), free-running, used to jitter the
// response latency when YSYX_23060240_SRAM_RAND_DELAY_EN is defined.
module ysyx_23060240_lfsr8
   import ysyx_23060240_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] out
);

   // Shift left, feeding back the XOR of stages 8,6,5,4.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out <= LFSR_SEED;
      else        out <= {out[6:0], out[7] ^ out[5] ^ out[4] ^ out[3]};
   end

endmodule

// File: rtl/ysyx_23060240_sram_resp.sv
// Valid/ready SRAM responder with independent read and write FSMs, fixed
// response latency and a word-addressed storage array (not reset).
// Optional macro YSYX_23060240_SRAM_RAND_DELAY_EN adds 0-7 random extra
// cycles per transaction from an 8-bit LFSR.
module ysyx_23060240_sram_resp
   import ysyx_23060240_pkg::*;
#(
   parameter logic [31:0] BASE   = 32'h8000_0000,
   parameter int          DEPTH  = 1024,
   parameter int          RD_LAT = 1,
   parameter int          WR_LAT = 1
) (
   input logic                     clk,
   input logic                     rst_n,
   ysyx_23060240_sram_resp_if.slave bus
);

   localparam int          IW   = $clog2(DEPTH);
   localparam logic [31:0] SPAN = 32'(4 * DEPTH);

   typedef logic [IW-1:0] idx_t;

   // Unsigned wrap of the offset makes addresses below BASE fail the check too.
   function automatic logic addr_ok(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return off < SPAN;
   endfunction

   function automatic idx_t addr_idx(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return idx_t'(off >> 2);
   endfunction

   logic [31:0] mem [DEPTH];

   logic [7:0] rd_lat, wr_lat;
`ifdef YSYX_23060240_SRAM_RAND_DELAY_EN
   logic [7:0] lfsr;
   ysyx_23060240_lfsr8 u_lfsr (.clk(clk), .rst_n(rst_n), .out(lfsr));
   assign rd_lat = 8'(RD_LAT) + (lfsr & 8'h07);
   assign wr_lat = 8'(WR_LAT) + (lfsr & 8'h07);
`else
   assign rd_lat = 8'(RD_LAT);
   assign wr_lat = 8'(WR_LAT);
`endif

   // ---------------- read channel ----------------
   r_state_t    r_state, r_state_next;
   logic [7:0]  r_cnt_reg, r_cnt_next;
   logic [31:0] r_addr_reg, r_src_addr;
   logic [31:0] rdata_reg;
   logic [1:0]  rresp_reg;
   logic        r_load;

   // Read next-state: a total latency of 1 skips R_WAIT and samples the
   // array directly on the handshake edge.
   always_comb begin
      r_state_next = r_state;
      r_cnt_next   = r_cnt_reg;
      r_load       = 1'b0;
      r_src_addr   = r_addr_reg;
      case (r_state)
         R_IDLE: if (bus.arvalid) begin
            r_src_addr = bus.araddr;
            if (rd_lat <= 8'd1) begin
               r_state_next = R_RESP;
               r_load       = 1'b1;
            end else begin
               r_state_next = R_WAIT;
               r_cnt_next   = rd_lat - 8'd2;
            end
         end
         R_WAIT: if (r_cnt_reg == 8'd0) begin
            r_state_next = R_RESP;
            r_load       = 1'b1;
         end else begin
            r_cnt_next = r_cnt_reg - 8'd1;
         end
         R_RESP: if (bus.rready) r_state_next = R_IDLE;
         default: r_state_next = R_IDLE;
      endcase
   end

   // Read state, latched address and registered read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= R_IDLE;
         r_cnt_reg  <= 8'd0;
         r_addr_reg <= 32'd0;
         rdata_reg  <= 32'd0;
         rresp_reg  <= RESP_OKAY;
      end else begin
         r_state   <= r_state_next;
         r_cnt_reg <= r_cnt_next;
         if (r_state == R_IDLE && bus.arvalid) r_addr_reg <= bus.araddr;
         if (r_load) begin
            if (addr_ok(r_src_addr)) begin
               rdata_reg <= mem[addr_idx(r_src_addr)];
               rresp_reg <= RESP_OKAY;
            end else begin
               rdata_reg <= 32'd0;
               rresp_reg <= RESP_SLVERR;
            end
         end
      end
   end

   assign bus.arready = (r_state == R_IDLE);
   assign bus.rvalid  = (r_state == R_RESP);
   assign bus.rdata   = rdata_reg;
   assign bus.rresp   = rresp_reg;

   // ---------------- write channel ----------------
   w_state_t    w_state, w_state_next;
   logic [7:0]  w_cnt_reg, w_cnt_next;
   logic        aw_got_reg, w_got_reg;
   logic [31:0] aw_addr_reg, w_data_reg;
   logic [3:0]  w_strb_reg;
   logic [1:0]  bresp_reg;
   logic        aw_fire, w_fire, both;
   logic        w_commit;
   logic [31:0] c_addr, c_data;
   logic [3:0]  c_strb;

   assign aw_fire = (w_state == W_IDLE) && !aw_got_reg && bus.awvalid;
   assign w_fire  = (w_state == W_IDLE) && !w_got_reg  && bus.wvalid;
   assign both    = (aw_got_reg || aw_fire) && (w_got_reg || w_fire);

   // Write next-state: the commit uses the bus values when the last
   // handshake and the commit fall on the same edge, otherwise the latches.
   always_comb begin
      w_state_next = w_state;
      w_cnt_next   = w_cnt_reg;
      w_commit     = 1'b0;
      c_addr       = aw_addr_reg;
      c_data       = w_data_reg;
      c_strb       = w_strb_reg;
      case (w_state)
         W_IDLE: if (both) begin
            if (!aw_got_reg) c_addr = bus.awaddr;
            if (!w_got_reg) begin
               c_data = bus.wdata;
               c_strb = bus.wstrb;
            end
            if (wr_lat <= 8'd1) begin
               w_state_next = W_RESP;
               w_commit     = 1'b1;
            end else begin
               w_state_next = W_WAIT;
               w_cnt_next   = wr_lat - 8'd2;
            end
         end
         W_WAIT: if (w_cnt_reg == 8'd0) begin
            w_state_next = W_RESP;
            w_commit     = 1'b1;
         end else begin
            w_cnt_next = w_cnt_reg - 8'd1;
         end
         W_RESP: if (bus.bready) w_state_next = W_IDLE;
         default: w_state_next = W_IDLE;
      endcase
   end

   // Write state, AW/W latches and registered response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state     <= W_IDLE;
         w_cnt_reg   <= 8'd0;
         aw_got_reg  <= 1'b0;
         w_got_reg   <= 1'b0;
         aw_addr_reg <= 32'd0;
         w_data_reg  <= 32'd0;
         w_strb_reg  <= 4'd0;
         bresp_reg   <= RESP_OKAY;
      end else begin
         w_state   <= w_state_next;
         w_cnt_reg <= w_cnt_next;
         if (aw_fire) begin
            aw_got_reg  <= 1'b1;
            aw_addr_reg <= bus.awaddr;
         end
         if (w_fire) begin
            w_got_reg  <= 1'b1;
            w_data_reg <= bus.wdata;
            w_strb_reg <= bus.wstrb;
         end
         if (w_state == W_RESP && bus.bready) begin
            aw_got_reg <= 1'b0;
            w_got_reg  <= 1'b0;
         end
         if (w_commit) bresp_reg <= addr_ok(c_addr) ? RESP_OKAY : RESP_SLVERR;
      end
   end

   // Storage write port; a reset held across the commit edge drops the write.
   always_ff @(posedge clk) begin
      if (rst_n && w_commit && addr_ok(c_addr)) begin
         for (int b = 0; b < 4; b++) begin
            if (c_strb[b]) mem[addr_idx(c_addr)][8*b +: 8] <= c_data[8*b +: 8];
         end
      end
   end

   assign bus.awready = (w_state == W_IDLE) && !aw_got_reg;
   assign bus.wready  = (w_state == W_IDLE) && !w_got_reg;
   assign bus.bvalid  = (w_state == W_RESP);
   assign bus.bresp   = bresp_reg;

endmodule

// File: doc/ysyx_23060240_sram_resp.md
Name: ysyx_23060240_sram_resp

Overview:
- Memory-side responder for the core's load/store unit: a valid/ready (AXI4-Lite-style) slave.
- Has independent read and write channels, fixed-latency (optionally randomised) responses, and an internal word-addressed storage array.
- Sits between the core's memory-access initiator and storage, replacing direct combinational memory calls.
- Lets the pipeline be tested against realistic multi-cycle, back-pressured memory.

Parameters:
- BASE, 32'h8000_0000, byte address of word 0
- DEPTH, 1024, number of 32-bit words (power of two)
- RD_LAT, 1, cycles from AR handshake to rvalid (>=1)
- WR_LAT, 1, cycles from the later of the AW/W handshakes to bvalid (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- araddr  in  32  read byte address
- arvalid  in  1  read request valid
- arready  out  1  read request accepted
- rdata  out  32  read data, full word
- rresp  out  2  read response: 00 OKAY, 10 SLVERR
- rvalid  out  1  read data valid
- rready  in  1  initiator accepts read data
- awaddr  in  32  write byte address
- awvalid  in  1  write address valid
- awready  out  1  write address accepted
- wdata  in  32  write data
- wstrb  in  4  byte enables; bit i enables wdata[8i+7:8i]
- wvalid  in  1  write data valid
- wready  out  1  write data accepted
- bresp  out  2  write response: 00 OKAY, 10 SLVERR
- bvalid  out  1  write response valid
- bready  in  1  initiator accepts write response

Behaviour:
- Reset values: arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
  - Reset clears all state, counters and latched requests.
  - Storage array is not reset.
- Address decode: word index = (addr-BASE)>>2.
  - addr[1:0] is ignored; no misalignment error.
  - In range iff BASE <= addr < BASE+4*DEPTH.
- Read FSM R_IDLE -> R_WAIT -> R_RESP:
  - R_IDLE: arready=1. On arvalid&arready, latch the address and load the latency counter.
  - R_WAIT: arready=0. Counts down. rvalid rises exactly RD_LAT cycles after the handshake cycle.
  - Array is sampled on the R_WAIT->R_RESP edge.
  - R_RESP: rvalid=1; rdata/rresp held stable until rready. On rvalid&rready, return to R_IDLE.
  - The next AR is not accepted in the same cycle as the R handshake.
  - Out of range: rdata=0, rresp=10.
- Write FSM W_IDLE -> W_WAIT -> W_RESP:
  - W_IDLE: awready=1 until AW is latched; wready=1 until W is latched. AW and W are accepted in either order or together.
  - Once both are latched, enter W_WAIT; bvalid rises exactly WR_LAT cycles after the later handshake.
  - Array is written on the W_WAIT->W_RESP edge, per wstrb.
  - W_RESP: bvalid=1, held until bready, then W_IDLE.
  - Out of range: no array write, bresp=10.
  - wstrb=0: no write, bresp=00.
- Channel independence: read and write FSMs run concurrently.
  - If a read samples the same word on the same edge a write commits, the read returns the OLD value.
- Back-pressure: rready/bready may stay low indefinitely; no new request is accepted on that channel meanwhile.
- Reset mid-operation: all in-flight transactions are dropped; no response is issued.
  - A write is lost if reset arrives before its commit edge.

Optional Feature:
- Macro: YSYX_23060240_SRAM_RAND_DELAY_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) advances every cycle.
  - At each AR handshake, or at the W_IDLE->W_WAIT transition, lfsr[2:0] is sampled and added to RD_LAT/WR_LAT (0-7 extra cycles).
  - The read and write channels each use the LFSR value of their own sampling cycle.
- Undefined: no LFSR logic; latencies are exactly RD_LAT/WR_LAT.

Decomposition:
- Package ysyx_23060240_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - read-FSM and write-FSM state encodings
  - LFSR_SEED=8'hA5
- Sub-module ysyx_23060240_lfsr8:
  - ports clk, rst_n, out[7:0]
  - instantiated only under the macro

Test Plan:
- Write 0x8000_0010 data 0xDEADBEEF wstrb 1111 (AW and W same cycle), then read the same address -> bvalid after WR_LAT, bresp=00; rvalid exactly RD_LAT cycles after AR handshake, rdata=0xDEADBEEF, rresp=00.
- Write 0x1122_3344 full word, then wstrb 0101 with 0xAABBCCDD to same address -> subsequent read returns 0x11BB_33DD.
- W before AW: wvalid at cycle 0, awvalid at cycle 3 -> wready drops after cycle 0; bvalid WR_LAT cycles after cycle 3.
- Read 0x7FFF_FFFC and write BASE+4*DEPTH -> rresp=10, rdata=0; bresp=10; array unchanged (verify by in-range read).
- Hold rready low 5 cycles in R_RESP -> rvalid and rdata stable; arready=0 throughout; arready=1 the cycle after the handshake.
- Assert rst_n=0 while in R_WAIT and W_WAIT -> next cycle rvalid=bvalid=0, all readys=1; the pending write is not committed.
